// File: rtl/mem_wb_stage_controller.sv
// mem_wb_stage_controller
//   Sequences the MEM stage of a 5-stage MIPS pipeline around a data memory
//   with a req/ack handshake. Stalls upstream stages while a load/store is
//   outstanding, drives the MEM/WB load enable and bubble insertion, and
//   retires failed or timed-out accesses as bubbles with sticky status.
//
// Ports:
//   i_clk             pipeline clock, rising edge
//   i_reset           asynchronous active-high reset
//   i_exmem_valid     EX/MEM holds a real instruction
//   i_exmem_memread   instruction is a load
//   i_exmem_memwrite  instruction is a store (wins if both set)
//   i_dmem_ack        data memory access complete (1-cycle pulse)
//   i_dmem_err        data memory access fault
//   o_dmem_req        registered access request
//   o_dmem_we         registered write enable, stable while o_dmem_req=1
//   o_pipe_stall      freeze PC, IF/ID, ID/EX, EX/MEM
//   o_memwb_load      MEM/WB register load enable
//   o_memwb_bubble    force RegWrite/MemtoReg to 0 on MEM/WB input
//   o_busy            controller not idle
//   o_timeout_err     sticky: an access timed out
//   o_access_err      sticky: dmem_err seen during an access
//   o_stall_cycles    saturating count of stalled cycles
//
// state | meaning
// IDLE  | no access outstanding; non-memory instructions pass straight through
// REQ   | request outstanding, waiting for ack/err or timeout
// DONE  | access completed; instruction retires into MEM/WB
// ABORT | access failed or timed out; instruction dropped as a bubble
module mem_wb_stage_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5,
  parameter int PERF_W         = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_exmem_valid,
  input  logic              i_exmem_memread,
  input  logic              i_exmem_memwrite,
  input  logic              i_dmem_ack,
  input  logic              i_dmem_err,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic              o_pipe_stall,
  output logic              o_memwb_load,
  output logic              o_memwb_bubble,
  output logic              o_busy,
  output logic              o_timeout_err,
  output logic              o_access_err,
  output logic [PERF_W-1:0] o_stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ABORT} state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_req;
  logic               r_we;
  logic               r_timeout_err;
  logic               r_access_err;
  logic [PERF_W-1:0]  r_stall_cycles;

  logic w_mem_op;
  logic w_start;
  logic w_err_abort;
  logic w_to_abort;
  logic w_exit_req;

  assign w_mem_op = i_exmem_valid & (i_exmem_memread | i_exmem_memwrite);

  always_comb begin
    w_next         = r_state;
    o_pipe_stall   = 1'b0;
    o_memwb_load   = 1'b1;
    o_memwb_bubble = 1'b1;
    w_start        = 1'b0;
    w_err_abort    = 1'b0;
    w_to_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          o_pipe_stall = 1'b1;
          w_start      = 1'b1;
          w_next       = S_REQ;
        end else begin
          o_memwb_bubble = ~i_exmem_valid;
        end
      end
      S_REQ: begin
        o_pipe_stall = 1'b1;
        // Error takes priority over a simultaneous ack.
        if (i_dmem_err) begin
          w_err_abort = 1'b1;
          w_next      = S_ABORT;
        end else if (i_dmem_ack) begin
          w_next = S_DONE;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_to_abort = 1'b1;
          w_next     = S_ABORT;
        end
      end
      S_DONE: begin
        o_memwb_bubble = 1'b0;
        w_next         = S_IDLE;
      end
      S_ABORT: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_exit_req = (r_state == S_REQ) && (w_next != S_REQ);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_req          <= 1'b0;
      r_we           <= 1'b0;
      r_cnt          <= '0;
      r_timeout_err  <= 1'b0;
      r_access_err   <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_req <= 1'b1;
        r_we  <= i_exmem_memwrite;
        r_cnt <= '0;
      end else if (w_exit_req) begin
        r_req <= 1'b0;
      end else if (r_state == S_REQ) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_err_abort) r_access_err  <= 1'b1;
      if (w_to_abort)  r_timeout_err <= 1'b1;
      if (o_pipe_stall && (r_stall_cycles != {PERF_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign o_dmem_req     = r_req;
  assign o_dmem_we      = r_we;
  assign o_busy         = (r_state != S_IDLE);
  assign o_timeout_err  = r_timeout_err;
  assign o_access_err   = r_access_err;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_mem_wb_stage_controller.sv
// tb_mem_wb_stage_controller
//   Directed vectors for mem_wb_stage_controller. Each vector drives one
//   cycle of inputs and queues the hand-computed outputs for that cycle;
//   a monitor samples the DUT on the falling edge and compares.
module tb_mem_wb_stage_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, rd, wr, ack, err;
  logic        req, we, stall, load, bubble, busy, terr, aerr;
  logic [31:0] sc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_stage_controller #(
    .TIMEOUT_CYCLES(16),
    .CNT_W(5),
    .PERF_W(32)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_exmem_valid(valid),
    .i_exmem_memread(rd),
    .i_exmem_memwrite(wr),
    .i_dmem_ack(ack),
    .i_dmem_err(err),
    .o_dmem_req(req),
    .o_dmem_we(we),
    .o_pipe_stall(stall),
    .o_memwb_load(load),
    .o_memwb_bubble(bubble),
    .o_busy(busy),
    .o_timeout_err(terr),
    .o_access_err(aerr),
    .o_stall_cycles(sc)
  );

  // flags order: {stall, load, bubble, busy, req, we, terr, aerr}
  logic [7:0]  q_flags[$];
  logic [31:0] q_sc[$];
  string       q_name[$];

  always @(negedge clk) begin
    if (q_flags.size() > 0) begin
      logic [7:0]  ef, af;
      logic [31:0] es;
      string       nm;
      ef = q_flags.pop_front();
      es = q_sc.pop_front();
      nm = q_name.pop_front();
      af = {stall, load, bubble, busy, req, we, terr, aerr};
      // dmem_we only has meaning while a request is outstanding
      if (!ef[3]) af[2] = ef[2];
      n_checks++;
      if (af !== ef || sc !== es) begin
        n_fail++;
        $display("FAIL %s: got flags=%b stall_cycles=%0d, expected flags=%b stall_cycles=%0d",
                 nm, af, sc, ef, es);
      end
    end
  end

  task automatic step(input string name, input logic v, input logic r, input logic w,
                      input logic a, input logic e, input logic rs,
                      input logic [7:0] f, input int exp_sc);
    @(posedge clk);
    #1;
    valid = v; rd = r; wr = w; ack = a; err = e; rst = rs;
    q_flags.push_back(f);
    q_sc.push_back(32'(exp_sc));
    q_name.push_back(name);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; rd = 1'b0; wr = 1'b0; ack = 1'b0; err = 1'b0;
    //                                v  r  w  a  e  rs  st ld bu by rq we te ae
    step("reset",         0, 0, 0, 0, 0, 1, 8'b0_1_1_0_0_0_0_0, 0);
    for (int i = 0; i < 3; i++)
      step("alu",         1, 0, 0, 0, 0, 0, 8'b0_1_0_0_0_0_0_0, 0);

    // load, ack on first REQ cycle
    step("ld_idle",       1, 1, 0, 0, 0, 0, 8'b1_1_1_0_0_0_0_0, 0);
    step("ld_req_ack",    1, 1, 0, 1, 0, 0, 8'b1_1_1_1_1_0_0_0, 1);
    step("ld_done",       1, 1, 0, 0, 0, 0, 8'b0_1_0_1_0_0_0_0, 2);
    step("ld_after",      1, 0, 0, 0, 0, 0, 8'b0_1_0_0_0_0_0_0, 2);

    // store, ack on 4th REQ cycle
    step("st_idle",       1, 0, 1, 0, 0, 0, 8'b1_1_1_0_0_0_0_0, 2);
    for (int i = 0; i < 3; i++)
      step("st_req_wait", 1, 0, 1, 0, 0, 0, 8'b1_1_1_1_1_1_0_0, 3 + i);
    step("st_req_ack",    1, 0, 1, 1, 0, 0, 8'b1_1_1_1_1_1_0_0, 6);
    step("st_done",       1, 0, 1, 0, 0, 0, 8'b0_1_0_1_0_0_0_0, 7);
    step("st_after",      1, 0, 0, 0, 0, 0, 8'b0_1_0_0_0_0_0_0, 7);

    // load never acked: aborts after 16 REQ cycles
    step("to_idle",       1, 1, 0, 0, 0, 0, 8'b1_1_1_0_0_0_0_0, 7);
    for (int k = 1; k <= 16; k++)
      step("to_req",      1, 1, 0, 0, 0, 0, 8'b1_1_1_1_1_0_0_0, 7 + k);
    step("to_abort",      1, 1, 0, 0, 0, 0, 8'b0_1_1_1_0_0_1_0, 24);
    step("to_after1",     1, 0, 0, 0, 0, 0, 8'b0_1_0_0_0_0_1_0, 24);
    step("to_after2",     1, 0, 0, 0, 0, 0, 8'b0_1_0_0_0_0_1_0, 24);

    // err together with ack: error wins
    step("er_idle",       1, 1, 0, 0, 0, 0, 8'b1_1_1_0_0_0_1_0, 24);
    step("er_req",        1, 1, 0, 1, 1, 0, 8'b1_1_1_1_1_0_1_0, 25);
    step("er_abort",      1, 1, 0, 0, 0, 0, 8'b0_1_1_1_0_0_1_1, 26);
    // stray ack in IDLE with no instruction
    step("ack_idle",      0, 0, 0, 1, 0, 0, 8'b0_1_1_0_0_0_1_1, 26);
    step("ack_idle_post", 0, 0, 0, 0, 0, 0, 8'b0_1_1_0_0_0_1_1, 26);

    // reset asserted in the 3rd REQ cycle of a store
    step("rs_idle",       1, 0, 1, 0, 0, 0, 8'b1_1_1_0_0_0_1_1, 26);
    step("rs_req1",       1, 0, 1, 0, 0, 0, 8'b1_1_1_1_1_1_1_1, 27);
    step("rs_req2",       1, 0, 1, 0, 0, 0, 8'b1_1_1_1_1_1_1_1, 28);
    step("rs_mid_req",    0, 0, 0, 0, 0, 1, 8'b0_1_1_0_0_0_0_0, 0);
    step("rs_after",      1, 0, 0, 0, 0, 0, 8'b0_1_0_0_0_0_0_0, 0);
    step("rs_after2",     1, 0, 0, 0, 0, 0, 8'b0_1_0_0_0_0_0_0, 0);

    for (int i = 0; i < 20 && q_flags.size() > 0; i++) @(posedge clk);
    if (q_flags.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q_flags.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
